// File: rtl/digi_alarm_clock.sv
// 24-hour clock with N_ALARMS alarm channels, ring timeout and optional snooze.
// Define DIGI_ALARM_SNOOZE_EN to build the SNOOZE state and honour the snooze input.
module digi_alarm_clock #(
  parameter  int N_ALARMS       = 4,
  parameter  int SNOOZE_MIN     = 5,
  parameter  int RING_TIMEOUT_S = 60,
  localparam int IDXW           = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            tick_1hz,
  input  logic            set_time,
  input  logic [4:0]      set_hours,
  input  logic [5:0]      set_minutes,
  input  logic [5:0]      set_seconds,
  input  logic            alarm_wr,
  input  logic [IDXW-1:0] alarm_idx,
  input  logic [4:0]      alarm_hours_in,
  input  logic [5:0]      alarm_minutes_in,
  input  logic            alarm_en_in,
  input  logic            snooze,
  input  logic            dismiss,
  output logic [4:0]      hours,
  output logic [5:0]      minutes,
  output logic [5:0]      seconds,
  output logic            alarm_ring,
  output logic [IDXW-1:0] alarm_src
);

  localparam int RW = 10;

`ifdef DIGI_ALARM_SNOOZE_EN
  localparam int SNW          = 12;
  localparam int SNOOZE_TICKS = SNOOZE_MIN * 60;
  typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_e;
  logic [SNW-1:0] snz_cnt_q;
`else
  typedef enum logic [1:0] {IDLE, RING} state_e;
  logic unused_snooze;
  assign unused_snooze = snooze;
`endif

  state_e          state_q;
  logic [RW-1:0]   ring_cnt_q;
  logic            alarm_ring_q;
  logic [IDXW-1:0] alarm_src_q;

  logic [4:0] hours_q, hours_d;
  logic [5:0] minutes_q, minutes_d;
  logic [5:0] seconds_q, seconds_d;

  logic [4:0] alm_h_q  [N_ALARMS];
  logic [5:0] alm_m_q  [N_ALARMS];
  logic       alm_en_q [N_ALARMS];

  logic            match_tick;
  logic            match;
  logic [IDXW-1:0] match_idx;

  always_comb begin
    hours_d   = hours_q;
    minutes_d = minutes_q;
    seconds_d = seconds_q;
    if (set_time) begin
      hours_d   = (set_hours   > 5'd23) ? 5'd0 : set_hours;
      minutes_d = (set_minutes > 6'd59) ? 6'd0 : set_minutes;
      seconds_d = (set_seconds > 6'd59) ? 6'd0 : set_seconds;
    end else if (tick_1hz) begin
      if (seconds_q == 6'd59) begin
        seconds_d = 6'd0;
        if (minutes_q == 6'd59) begin
          minutes_d = 6'd0;
          hours_d   = (hours_q == 5'd23) ? 5'd0 : hours_q + 5'd1;
        end else begin
          minutes_d = minutes_q + 6'd1;
        end
      end else begin
        seconds_d = seconds_q + 6'd1;
      end
    end
  end

  // Only a tick that rolls seconds to zero can match; scanning downward leaves the lowest index.
  assign match_tick = tick_1hz && !set_time && (seconds_q == 6'd59);

  always_comb begin
    match     = 1'b0;
    match_idx = '0;
    for (int i = N_ALARMS - 1; i >= 0; i--) begin
      if (alm_en_q[i] && alm_h_q[i] == hours_d && alm_m_q[i] == minutes_d) begin
        match     = match_tick;
        match_idx = IDXW'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hours_q   <= '0;
      minutes_q <= '0;
      seconds_q <= '0;
    end else begin
      hours_q   <= hours_d;
      minutes_q <= minutes_d;
      seconds_q <= seconds_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_ALARMS; i++) begin
        alm_h_q[i]  <= '0;
        alm_m_q[i]  <= '0;
        alm_en_q[i] <= 1'b0;
      end
    end else if (alarm_wr) begin
      for (int i = 0; i < N_ALARMS; i++) begin
        if (alarm_idx == IDXW'(i)) begin
          alm_h_q[i]  <= alarm_hours_in;
          alm_m_q[i]  <= alarm_minutes_in;
          alm_en_q[i] <= alarm_en_in;
        end
      end
    end
  end

  // Dismiss outranks snooze, which outranks the ring timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ring_cnt_q   <= '0;
      alarm_ring_q <= 1'b0;
      alarm_src_q  <= '0;
`ifdef DIGI_ALARM_SNOOZE_EN
      snz_cnt_q    <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (match) begin
            state_q      <= RING;
            ring_cnt_q   <= '0;
            alarm_ring_q <= 1'b1;
            alarm_src_q  <= match_idx;
          end
        end
        RING: begin
          if (dismiss) begin
            state_q      <= IDLE;
            alarm_ring_q <= 1'b0;
`ifdef DIGI_ALARM_SNOOZE_EN
          end else if (snooze) begin
            state_q      <= SNOOZE;
            alarm_ring_q <= 1'b0;
            snz_cnt_q    <= '0;
`endif
          end else if (tick_1hz) begin
            if (ring_cnt_q == RW'(RING_TIMEOUT_S - 1)) begin
              state_q      <= IDLE;
              alarm_ring_q <= 1'b0;
            end else begin
              ring_cnt_q <= ring_cnt_q + RW'(1);
            end
          end
        end
`ifdef DIGI_ALARM_SNOOZE_EN
        SNOOZE: begin
          if (dismiss) begin
            state_q <= IDLE;
          end else if (tick_1hz) begin
            if (snz_cnt_q == SNW'(SNOOZE_TICKS - 1)) begin
              state_q      <= RING;
              ring_cnt_q   <= '0;
              alarm_ring_q <= 1'b1;
            end else begin
              snz_cnt_q <= snz_cnt_q + SNW'(1);
            end
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign hours      = hours_q;
  assign minutes    = minutes_q;
  assign seconds    = seconds_q;
  assign alarm_ring = alarm_ring_q;
  assign alarm_src  = alarm_src_q;

endmodule

// File: tb/tb_digi_alarm_clock.sv
// Self-checking bench for digi_alarm_clock: table of timekeeping vectors plus
// hand-written alarm, snooze and reset sequences, checked through an expectation queue.
module tb_digi_alarm_clock;

  localparam int N_ALARMS       = 4;
  localparam int SNOOZE_MIN     = 5;
  localparam int RING_TIMEOUT_S = 60;
  localparam int IDXW           = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            tick_1hz, set_time, alarm_wr, alarm_en_in, snooze, dismiss;
  logic [4:0]      set_hours, alarm_hours_in;
  logic [5:0]      set_minutes, set_seconds, alarm_minutes_in;
  logic [IDXW-1:0] alarm_idx;
  logic [4:0]      hours;
  logic [5:0]      minutes, seconds;
  logic            alarm_ring;
  logic [IDXW-1:0] alarm_src;

  digi_alarm_clock #(
    .N_ALARMS(N_ALARMS),
    .SNOOZE_MIN(SNOOZE_MIN),
    .RING_TIMEOUT_S(RING_TIMEOUT_S)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz),
    .set_time(set_time), .set_hours(set_hours), .set_minutes(set_minutes), .set_seconds(set_seconds),
    .alarm_wr(alarm_wr), .alarm_idx(alarm_idx), .alarm_hours_in(alarm_hours_in),
    .alarm_minutes_in(alarm_minutes_in), .alarm_en_in(alarm_en_in),
    .snooze(snooze), .dismiss(dismiss),
    .hours(hours), .minutes(minutes), .seconds(seconds),
    .alarm_ring(alarm_ring), .alarm_src(alarm_src)
  );

  always #5 clk = ~clk;

  typedef enum int {OP_NOP, OP_SET, OP_TICK, OP_SETTICK, OP_WR, OP_SNOOZE, OP_DISMISS, OP_SNZDIS} op_e;

  typedef struct {
    op_e op;
    int  h, m, s, idx, en;
    int  eh, em, es, ering, esrc;
  } vec_t;

  typedef struct {
    int eh, em, es, ering, esrc;
  } exp_t;

  exp_t expQ[$];
  vec_t tbl[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic vec_t V(op_e op, int h, int m, int s, int idx, int en,
                             int eh, int em, int es, int ering, int esrc);
    vec_t v;
    v.op = op; v.h = h; v.m = m; v.s = s; v.idx = idx; v.en = en;
    v.eh = eh; v.em = em; v.es = es; v.ering = ering; v.esrc = esrc;
    return v;
  endfunction

  task automatic clearInputs();
    tick_1hz = 1'b0; set_time = 1'b0; alarm_wr = 1'b0; snooze = 1'b0; dismiss = 1'b0;
  endtask

  // Drive one operation for a single clock and queue what the outputs must show afterwards.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    @(negedge clk);
    case (v.op)
      OP_SET, OP_SETTICK: begin
        set_time    = 1'b1;
        set_hours   = 5'(v.h);
        set_minutes = 6'(v.m);
        set_seconds = 6'(v.s);
        if (v.op == OP_SETTICK) tick_1hz = 1'b1;
      end
      OP_TICK: tick_1hz = 1'b1;
      OP_WR: begin
        alarm_wr         = 1'b1;
        alarm_idx        = IDXW'(v.idx);
        alarm_hours_in   = 5'(v.h);
        alarm_minutes_in = 6'(v.m);
        alarm_en_in      = v.en[0];
      end
      OP_SNOOZE:  snooze = 1'b1;
      OP_DISMISS: dismiss = 1'b1;
      OP_SNZDIS:  begin snooze = 1'b1; dismiss = 1'b1; end
      default: ;
    endcase
    @(posedge clk);
    #1;
    clearInputs();
    e.eh = v.eh; e.em = v.em; e.es = v.es; e.ering = v.ering; e.esrc = v.esrc;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input string name);
    exp_t e;
    checks++;
    if (expQ.size() == 0) begin
      failures++;
      $display("[TB] FAIL %s: no expected entry queued", name);
      return;
    end
    e = expQ.pop_front();
    if (hours !== 5'(e.eh) || minutes !== 6'(e.em) || seconds !== 6'(e.es) ||
        alarm_ring !== e.ering[0] || alarm_src !== IDXW'(e.esrc)) begin
      failures++;
      $display("[TB] FAIL %s: got %0d:%0d:%0d ring=%0d src=%0d, want %0d:%0d:%0d ring=%0d src=%0d",
               name, hours, minutes, seconds, alarm_ring, alarm_src,
               e.eh, e.em, e.es, e.ering, e.esrc);
    end
  endtask

  task automatic step(input string name, input vec_t v);
    applyStimulus(v);
    checkOutput(name);
  endtask

  task automatic expectNow(input string name, input int eh, input int em, input int es,
                           input int ering, input int esrc);
    exp_t e;
    e.eh = eh; e.em = em; e.es = es; e.ering = ering; e.esrc = esrc;
    expQ.push_back(e);
    checkOutput(name);
  endtask

  task automatic tickN(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tick_1hz = 1'b1;
      @(posedge clk);
      #1;
      tick_1hz = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    clearInputs();
    set_hours = '0; set_minutes = '0; set_seconds = '0;
    alarm_idx = '0; alarm_hours_in = '0; alarm_minutes_in = '0; alarm_en_in = 1'b0;

    tbl.push_back(V(OP_TICK,     0,  0,  0, 0, 0,  0,  0,  1, 0, 0));
    tbl.push_back(V(OP_SET,     12, 34, 56, 0, 0, 12, 34, 56, 0, 0));
    tbl.push_back(V(OP_TICK,     0,  0,  0, 0, 0, 12, 34, 57, 0, 0));
    tbl.push_back(V(OP_SET,     24, 60, 61, 0, 0,  0,  0,  0, 0, 0));
    tbl.push_back(V(OP_SET,     23, 59, 59, 0, 0, 23, 59, 59, 0, 0));
    tbl.push_back(V(OP_TICK,     0,  0,  0, 0, 0,  0,  0,  0, 0, 0));
    tbl.push_back(V(OP_SET,     10, 59, 59, 0, 0, 10, 59, 59, 0, 0));
    tbl.push_back(V(OP_TICK,     0,  0,  0, 0, 0, 11,  0,  0, 0, 0));
    tbl.push_back(V(OP_SET,     25, 30, 20, 0, 0,  0, 30, 20, 0, 0));
    tbl.push_back(V(OP_SET,     12, 60, 30, 0, 0, 12,  0, 30, 0, 0));
    tbl.push_back(V(OP_SET,     12, 30, 60, 0, 0, 12, 30,  0, 0, 0));
    tbl.push_back(V(OP_SETTICK,  3,  4,  5, 0, 0,  3,  4,  5, 0, 0));
    tbl.push_back(V(OP_TICK,     0,  0,  0, 0, 0,  3,  4,  6, 0, 0));
    tbl.push_back(V(OP_DISMISS,  0,  0,  0, 0, 0,  3,  4,  6, 0, 0));
    tbl.push_back(V(OP_SNOOZE,   0,  0,  0, 0, 0,  3,  4,  6, 0, 0));

    repeat (3) @(posedge clk);
    #1;
    expectNow("reset_state", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i]);
      checkOutput($sformatf("vec%0d", i));
    end

    step("wr_ch2",       V(OP_WR,   7, 30,  0, 2, 1,  3,  4,  6, 0, 0));
    step("set_0729",     V(OP_SET,  7, 29, 59, 0, 0,  7, 29, 59, 0, 0));
    step("ring_ch2",     V(OP_TICK, 0,  0,  0, 0, 0,  7, 30,  0, 1, 2));
    tickN(RING_TIMEOUT_S - 1);
    expectNow("ring_before_timeout", 7, 30, 59, 1, 2);
    step("ring_timeout", V(OP_TICK, 0,  0,  0, 0, 0,  7, 31,  0, 0, 2));

    step("wr_ch1",       V(OP_WR,   8,  0,  0, 1, 1,  7, 31,  0, 0, 2));
    step("wr_ch3",       V(OP_WR,   8,  0,  0, 3, 1,  7, 31,  0, 0, 2));
    step("set_0759",     V(OP_SET,  7, 59, 59, 0, 0,  7, 59, 59, 0, 2));
    step("ring_lowest",  V(OP_TICK, 0,  0,  0, 0, 0,  8,  0,  0, 1, 1));
    step("wr_in_ring",   V(OP_WR,   8,  0,  0, 3, 0,  8,  0,  0, 1, 1));
    step("dismiss_wins", V(OP_SNZDIS, 0, 0, 0, 0, 0,  8,  0,  0, 0, 1));

    step("set_0759b",    V(OP_SET,  7, 59, 59, 0, 0,  7, 59, 59, 0, 1));
    step("ring_again",   V(OP_TICK, 0,  0,  0, 0, 0,  8,  0,  0, 1, 1));
`ifdef DIGI_ALARM_SNOOZE_EN
    step("snooze",       V(OP_SNOOZE, 0, 0, 0, 0, 0,  8,  0,  0, 0, 1));
    tickN(SNOOZE_MIN * 60 - 1);
    expectNow("snooze_hold", 8, 4, 59, 0, 1);
    step("snooze_end",   V(OP_TICK, 0,  0,  0, 0, 0,  8,  5,  0, 1, 1));
    tickN(RING_TIMEOUT_S - 1);
    expectNow("rering_hold", 8, 5, 59, 1, 1);
    step("rering_timeout", V(OP_TICK, 0, 0, 0, 0, 0,  8,  6,  0, 0, 1));
`else
    step("snooze_ignored", V(OP_SNOOZE, 0, 0, 0, 0, 0, 8,  0,  0, 1, 1));
    tickN(RING_TIMEOUT_S - 1);
    expectNow("ring_hold", 8, 0, 59, 1, 1);
    step("ring_timeout2", V(OP_TICK, 0, 0, 0, 0, 0,  8,  1,  0, 0, 1));
`endif

    step("set_0759c",    V(OP_SET,  7, 59, 59, 0, 0,  7, 59, 59, 0, 1));
    step("ring_pre_rst", V(OP_TICK, 0,  0,  0, 0, 0,  8,  0,  0, 1, 1));
    #2;
    rst_n = 1'b0;
    #1;
    expectNow("mid_ring_reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst_set",   V(OP_SET,  7, 29, 59, 0, 0,  7, 29, 59, 0, 0));
    step("ch2_cleared",    V(OP_TICK, 0,  0,  0, 0, 0,  7, 30,  0, 0, 0));
    step("set_alarm_time", V(OP_SET,  7, 30,  0, 0, 0,  7, 30,  0, 0, 0));
    step("post_rst_set2",  V(OP_SET,  7, 59, 59, 0, 0,  7, 59, 59, 0, 0));
    step("ch1_cleared",    V(OP_TICK, 0,  0,  0, 0, 0,  8,  0,  0, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/digi_alarm_clock.md
DIGI_ALARM_CLOCK -- requirements
Module: digi_alarm_clock

Interface
REQ-001 SHALL provide parameter N_ALARMS, default 4, meaning number of independent alarm channels (1..16).
REQ-002 SHALL provide parameter SNOOZE_MIN, default 5, meaning snooze length in minutes (1..59).
REQ-003 SHALL provide parameter RING_TIMEOUT_S, default 60, meaning seconds of ringing before auto-dismiss (1..1023).
REQ-004 SHALL use one clock and an asynchronous, active-low reset, in the port order below; IDXW = max(1, clog2(N_ALARMS)).
REQ-005 clk  input  1  system clock, all state on rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 tick_1hz  input  1  one-clk-wide strobe, once per second.
REQ-008 set_time  input  1  one-clk pulse, loads set_hours/set_minutes/set_seconds.
REQ-009 set_hours, set_minutes, set_seconds  input  5, 6, 6  time load values.
REQ-010 alarm_wr  input  1  one-clk pulse, writes alarm channel alarm_idx.
REQ-011 alarm_idx  input  IDXW  channel written by alarm_wr.
REQ-012 alarm_hours_in, alarm_minutes_in, alarm_en_in  input  5, 6, 1  alarm time and enable.
REQ-013 snooze, dismiss  input  1 each  one-clk user pulses.
REQ-014 hours, minutes, seconds  output  5, 6, 6  registered current time.
REQ-015 alarm_ring  output  1  high while ringing.
REQ-016 alarm_src  output  IDXW  index of channel that caused the current/last ring.

Function
REQ-017 On tick_1hz, seconds SHALL count 0..59; 59->0 increments minutes in the same clk; minutes 59->0 increments hours; hours 23->0; time outputs update one clk after the tick.
REQ-018 set_time SHALL load the time one clk later; out-of-range loads (hours>23, min/sec>59) SHALL be clamped to 0 per field; set_time wins over a simultaneous tick_1hz.
REQ-019 alarm_wr SHALL update the indexed channel next clk; alarm_idx >= N_ALARMS SHALL be ignored; a write never alters an ongoing ring/snooze.
REQ-020 A match SHALL occur on a tick_1hz that makes seconds 0 when new hours:minutes equals an enabled channel; set_time never triggers a match; lowest matching index wins.
REQ-021 FSM states IDLE, RING, SNOOZE; IDLE->RING on match, latching alarm_src, alarm_ring high the clk the new time appears.
REQ-022 RING: dismiss -> IDLE; snooze -> SNOOZE; RING_TIMEOUT_S ticks elapsed in RING -> IDLE; ring-second counter restarts on every RING entry.
REQ-023 SNOOZE: alarm_ring low; after SNOOZE_MIN*60 ticks -> RING, same alarm_src; dismiss -> IDLE.
REQ-024 Matches in RING or SNOOZE SHALL be ignored; dismiss SHALL win over simultaneous snooze; snooze/dismiss in IDLE SHALL be ignored.
REQ-025 Counters SHALL be sized for their parameter maxima and never wrap before terminal count.

Reset
REQ-026 rst_n low SHALL immediately force time 00:00:00, all channels 00:00 disabled, FSM IDLE, alarm_ring 0, alarm_src 0, snooze/ring counters 0; mid-ring reset clears ringing.
REQ-027 First tick_1hz after rst_n release SHALL produce 00:00:01.

Configuration
REQ-028 Macro DIGI_ALARM_SNOOZE_EN: defined -> SNOOZE state and snooze input behave as REQ-022/023.
REQ-029 Without DIGI_ALARM_SNOOZE_EN: no SNOOZE state or snooze counter is built; snooze input is ignored; RING exits only by dismiss or timeout.

Verification
REQ-030 set_time 23:59:59, one tick -> 00:00:00; set_time 24:60:61 -> 00:00:00.
REQ-031 Channel 2 = 07:30 enabled, time 07:29:59, tick -> alarm_ring=1, alarm_src=2 at 07:30:00; RING_TIMEOUT_S ticks later -> alarm_ring=0.
REQ-032 Channels 1 and 3 both 08:00 enabled, time 07:59:59, tick -> alarm_src=1; dismiss+snooze same clk -> IDLE, alarm_ring=0.
REQ-033 With macro, ring then snooze -> alarm_ring=0; SNOOZE_MIN*60 ticks -> alarm_ring=1, alarm_src unchanged; without macro snooze has no effect.
REQ-034 rst_n low during RING -> alarm_ring=0 immediately, time 00:00:00, all channels disabled; set_time to alarm time -> no ring.
